ws_systolic_array: RTL and testbench

Weight-stationary systolic matrix engine with a parametrised ROWS×COLS grid of signed MAC PEs. It has built-in input skew, output deskew, a load/compute/drain control FSM and valid/ready streaming interfaces. The block sits between the operand SRAM readers and the output accumulator buffer. The compute fabric needs no external skewing or sequencing.

---
 rtl/ws_systolic_array.sv | 201 ++++++++++++++++++++
 tb/tb_ws_systolic_array.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws_systolic_array.sv
// Weight-stationary ROWSxCOLS signed MAC array with input skew, output deskew and job FSM.
// Optional WS_SYSTOLIC_SATURATE_EN: PE adders clamp instead of wrapping.
module ws_systolic_array #(
    parameter int unsigned ROWS      = 8,
    parameter int unsigned COLS      = 8,
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned ACC_SIZE  = 24
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [15:0]               num_vec_i,
    output logic                      busy_o,
    output logic                      done_o,
    input  logic                      w_valid_i,
    output logic                      w_ready_o,
    input  logic [COLS*WORD_SIZE-1:0] w_in_bus_i,
    input  logic                      a_valid_i,
    output logic                      a_ready_o,
    input  logic [ROWS*WORD_SIZE-1:0] a_in_bus_i,
    output logic                      out_valid_o,
    output logic [COLS*ACC_SIZE-1:0]  out_bus_o
);
    localparam int unsigned TagW = ROWS + COLS - 1;

    typedef enum logic [1:0] {StIdle, StLoad, StCompute, StDrain} state_e;

    state_e                    state_q, state_d;
    logic [15:0]               num_vec_q, num_vec_d;
    logic [15:0]               w_cnt_q, w_cnt_d, a_cnt_q, a_cnt_d, out_cnt_q, out_cnt_d;
    logic                      done_q, done_d;
    logic                      w_ready_q, a_ready_q, out_valid_q;
    logic [COLS*ACC_SIZE-1:0]  out_bus_q;
    logic [TagW-1:0]           tag_q;
    logic                      w_acc, a_acc;
    logic [ROWS*WORD_SIZE-1:0] inj;
    logic [COLS*ACC_SIZE-1:0]  dsk_bus;

    logic signed [WORD_SIZE-1:0] act_in [ROWS][COLS];
    logic signed [WORD_SIZE-1:0] wt     [ROWS][COLS];
    logic signed [ACC_SIZE-1:0]  psum   [ROWS][COLS];

    assign w_acc = w_valid_i & w_ready_q;
    assign a_acc = a_valid_i & a_ready_q;
    // Bubble slots push zeros so stale operands never reach the adders.
    assign inj   = a_acc ? a_in_bus_i : '0;

    always_comb begin
        state_d   = state_q;
        num_vec_d = num_vec_q;
        done_d    = 1'b0;
        w_cnt_d   = w_cnt_q + 16'(w_acc);
        a_cnt_d   = a_cnt_q + 16'(a_acc);
        out_cnt_d = out_cnt_q + 16'(tag_q[TagW-1]);
        unique case (state_q)
            StIdle: begin
                w_cnt_d   = '0;
                a_cnt_d   = '0;
                out_cnt_d = '0;
                if (start_i && (num_vec_i != 16'd0)) begin
                    state_d   = StLoad;
                    num_vec_d = num_vec_i;
                end
            end
            StLoad: if (w_acc && (w_cnt_q == 16'(ROWS - 1))) state_d = StCompute;
            StCompute: if (a_acc && (a_cnt_q == num_vec_q - 16'd1)) state_d = StDrain;
            StDrain: begin
                if (tag_q[TagW-1] && (out_cnt_q == num_vec_q - 16'd1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            num_vec_q   <= '0;
            w_cnt_q     <= '0;
            a_cnt_q     <= '0;
            out_cnt_q   <= '0;
            done_q      <= 1'b0;
            w_ready_q   <= 1'b0;
            a_ready_q   <= 1'b0;
            tag_q       <= '0;
            out_valid_q <= 1'b0;
            out_bus_q   <= '0;
        end else begin
            state_q     <= state_d;
            num_vec_q   <= num_vec_d;
            w_cnt_q     <= w_cnt_d;
            a_cnt_q     <= a_cnt_d;
            out_cnt_q   <= out_cnt_d;
            done_q      <= done_d;
            w_ready_q   <= (state_d == StLoad);
            a_ready_q   <= (state_d == StCompute);
            tag_q       <= {tag_q[TagW-2:0], a_acc};
            out_valid_q <= tag_q[TagW-1];
            if (tag_q[TagW-1]) out_bus_q <= dsk_bus;
        end
    end

    // Input skew: lane r is delayed r cycles before entering column 0.
    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        if (r == 0) begin : g_direct
            assign act_in[0][0] = inj[WORD_SIZE-1:0];
        end else begin : g_delay
            logic [WORD_SIZE-1:0] sk_q [r];
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int k = 0; k < r; k++) sk_q[k] <= '0;
                end else begin
                    sk_q[0] <= inj[(r+1)*WORD_SIZE-1 -: WORD_SIZE];
                    for (int k = 1; k < r; k++) sk_q[k] <= sk_q[k-1];
                end
            end
            assign act_in[r][0] = sk_q[r-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_pe
            logic signed [WORD_SIZE-1:0]   w_q, w_src;
            logic signed [ACC_SIZE-1:0]    p_q, p_d, p_src;
            logic signed [2*WORD_SIZE-1:0] prod;

            if (r == 0) begin : g_top
                assign w_src = w_in_bus_i[(c+1)*WORD_SIZE-1 -: WORD_SIZE];
                assign p_src = '0;
            end else begin : g_mid
                assign w_src = wt[r-1][c];
                assign p_src = psum[r-1][c];
            end

            assign prod = (2*WORD_SIZE)'(act_in[r][c]) * (2*WORD_SIZE)'(w_q);
`ifdef WS_SYSTOLIC_SATURATE_EN
            logic signed [ACC_SIZE:0] s_ext;
            assign s_ext = (ACC_SIZE+1)'(p_src) + (ACC_SIZE+1)'(prod);
            always_comb begin
                p_d = s_ext[ACC_SIZE-1:0];
                if (s_ext[ACC_SIZE] != s_ext[ACC_SIZE-1]) begin
                    p_d = s_ext[ACC_SIZE] ? {1'b1, {(ACC_SIZE-1){1'b0}}}
                                          : {1'b0, {(ACC_SIZE-1){1'b1}}};
                end
            end
`else
            assign p_d = p_src + ACC_SIZE'(prod);
`endif

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    w_q <= '0;
                    p_q <= '0;
                end else begin
                    if (w_acc) w_q <= w_src;
                    p_q <= p_d;
                end
            end
            assign wt[r][c]   = w_q;
            assign psum[r][c] = p_q;

            if (c < COLS - 1) begin : g_fwd
                logic signed [WORD_SIZE-1:0] a_q;
                always_ff @(posedge clk_i) begin
                    if (rst_i) a_q <= '0;
                    else       a_q <= act_in[r][c];
                end
                assign act_in[r][c+1] = a_q;
            end
        end
    end

    // Output deskew: column c waits COLS-1-c cycles so a vector's lanes leave together.
    for (genvar c = 0; c < COLS; c++) begin : g_dsk
        localparam int unsigned D = COLS - 1 - c;
        if (D == 0) begin : g_direct
            assign dsk_bus[(c+1)*ACC_SIZE-1 -: ACC_SIZE] = psum[ROWS-1][c];
        end else begin : g_delay
            logic [ACC_SIZE-1:0] dq [D];
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int k = 0; k < D; k++) dq[k] <= '0;
                end else begin
                    dq[0] <= psum[ROWS-1][c];
                    for (int k = 1; k < D; k++) dq[k] <= dq[k-1];
                end
            end
            assign dsk_bus[(c+1)*ACC_SIZE-1 -: ACC_SIZE] = dq[D-1];
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign w_ready_o   = w_ready_q;
    assign a_ready_o   = a_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_bus_o   = out_bus_q;

endmodule

// File: tb/tb_ws_systolic_array.sv
// Bench for ws_systolic_array: scoreboard of matrix products with due cycles plus directed jobs.
module tb_ws_systolic_array;
    localparam int R = 8;
    localparam int C = 8;
    localparam int W = 8;
    localparam int A = 24;
    localparam int Lat = R + C;

    logic clk = 1'b0;
    logic rst, start, w_valid, a_valid;
    logic [15:0] num_vec;
    logic [C*W-1:0] w_in_bus;
    logic [R*W-1:0] a_in_bus;
    logic busy, done, w_ready, a_ready, out_valid;
    logic [C*A-1:0] out_bus;
    logic busy16, done16, w_ready16, a_ready16, out_valid16;
    logic [C*16-1:0] out_bus16;

    ws_systolic_array #(.ROWS(R), .COLS(C), .WORD_SIZE(W), .ACC_SIZE(A)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .num_vec_i(num_vec),
        .busy_o(busy), .done_o(done),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_in_bus_i(w_in_bus),
        .a_valid_i(a_valid), .a_ready_o(a_ready), .a_in_bus_i(a_in_bus),
        .out_valid_o(out_valid), .out_bus_o(out_bus)
    );

    // Narrow-accumulator twin, driven in lockstep, used for the overflow case.
    ws_systolic_array #(.ROWS(R), .COLS(C), .WORD_SIZE(W), .ACC_SIZE(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .num_vec_i(num_vec),
        .busy_o(busy16), .done_o(done16),
        .w_valid_i(w_valid), .w_ready_o(w_ready16), .w_in_bus_i(w_in_bus),
        .a_valid_i(a_valid), .a_ready_o(a_ready16), .a_in_bus_i(a_in_bus),
        .out_valid_o(out_valid16), .out_bus_o(out_bus16)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    typedef struct { int due; logic [C*A-1:0] val; } exp_t;
    typedef struct { logic [R*W-1:0] a; logic [C*A-1:0] y; } vec_t;

    exp_t           exp_q[$];
    logic [C*W-1:0] wq[$];
    logic [C*A-1:0] obs[$];
    logic [R*W-1:0] a_vecs[$];
    bit             vpat[$];
    logic [C*W-1:0] w_rows[R];
    logic [C*16-1:0] last16;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference: out[c] = sum_r a[r]*W[r][c]; W[r] is the (ROWS-1-r)th beat of the last load.
    function automatic logic [C*A-1:0] model(input logic [R*W-1:0] a);
        logic [C*A-1:0]     res;
        logic [C*W-1:0]     row;
        logic signed [W-1:0] av, wv;
        logic signed [31:0] s;
        res = '0;
        for (int c = 0; c < C; c++) begin
            s = 0;
            for (int r = 0; r < R; r++) begin
                row = wq[R-1-r];
                av  = a[r*W +: W];
                wv  = row[c*W +: W];
                s   = s + 32'(av) * 32'(wv);
            end
            res[c*A +: A] = s[A-1:0];
        end
        return res;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            wq.delete();
            for (int i = 0; i < R; i++) wq.push_back('0);
        end else begin
            if (w_valid && w_ready) begin
                wq.push_back(w_in_bus);
                void'(wq.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                check("out_valid at due cycle", 256'(out_valid), 256'(1));
                check("out_bus value", 256'(out_bus), 256'(exp_q[0].val));
                obs.push_back(out_bus);
                last16 = out_bus16;
                void'(exp_q.pop_front());
            end else begin
                check("out_valid off-slot", 256'(out_valid), 256'(0));
            end
            if (a_valid && a_ready) begin
                exp_t e;
                e.due = cyc + Lat;
                e.val = model(a_in_bus);
                exp_q.push_back(e);
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n, output int t0);
        start   = 1'b1;
        num_vec = 16'(n);
        t0      = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic load_w(input bit stall);
        int k = 0;
        int g = 0;
        while (k < R && g < 200) begin
            w_valid  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            w_in_bus = w_rows[k];
            @(negedge clk);
            if (w_valid && w_ready) k++;
            tick();
            g++;
        end
        w_valid = 1'b0;
        check("weight beats accepted", 256'(k), 256'(R));
    endtask

    // mode 0: always valid, 1: vpat then valid, 2: random valid.
    task automatic stream(input int n, input int mode, input bit poke);
        int i = 0;
        int j = 0;
        while (i < n && j < 400) begin
            case (mode)
                0: a_valid = 1'b1;
                1: a_valid = (j < vpat.size()) ? vpat[j] : 1'b1;
                default: a_valid = ($urandom_range(0, 3) != 0);
            endcase
            a_in_bus = a_valid ? a_vecs[i] : {$urandom, $urandom};
            start    = poke && (j == 1);
            if (poke && j == 1) num_vec = 16'd3;
            @(negedge clk);
            if (a_valid && a_ready) i++;
            tick();
            j++;
        end
        a_valid = 1'b0;
        start   = 1'b0;
        check("activation beats accepted", 256'(i), 256'(n));
    endtask

    task automatic wait_done(input int t0, input int exp_dur, input bit chk);
        int  g = 0;
        bit  seen = 0;
        int  d0 = done_cnt;
        int  dur = 0;
        check("busy while draining", 256'(busy), 256'(1));
        while (!seen && g < 300) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                dur  = cyc - t0;
            end else begin
                tick();
                g++;
            end
        end
        check("done seen", 256'(seen), 256'(1));
        if (chk) check("job duration", 256'(dur), 256'(exp_dur));
        repeat (3) tick();
        @(negedge clk);
        check("single done pulse", 256'(done_cnt - d0), 256'(1));
        check("idle after job", 256'(busy), 256'(0));
        tick();
    endtask

    task automatic rand_weights();
        for (int k = 0; k < R; k++) w_rows[k] = {$urandom, $urandom};
    endtask

    task automatic rand_acts(input int n);
        a_vecs.delete();
        for (int i = 0; i < n; i++) a_vecs.push_back({$urandom, $urandom});
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1);
    end

    initial begin
        vec_t tbl[4];
        int   t0, n;
        logic [C*A-1:0] v;
        logic [A-1:0]   lane;
        logic [15:0]    sat_exp;

        for (int i = 0; i < 4; i++) begin
            tbl[i].a = '0;
            tbl[i].y = '0;
            for (int r = 0; r < R; r++) tbl[i].a[r*W +: W] = W'((r + 1) * (i + 1));
            for (int c = 0; c < C; c++) tbl[i].y[c*A +: A] = A'((c + 1) * (i + 1));
        end

        // Reset with random inputs.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start = 1'(($urandom));  num_vec = 16'($urandom);
            w_valid = 1'b1;  a_valid = 1'b1;
            w_in_bus = {$urandom, $urandom};  a_in_bus = {$urandom, $urandom};
            @(negedge clk);
            check("reset busy", 256'(busy), 256'(0));
            check("reset done", 256'(done), 256'(0));
            check("reset w_ready", 256'(w_ready), 256'(0));
            check("reset a_ready", 256'(a_ready), 256'(0));
            check("reset out_valid", 256'(out_valid), 256'(0));
            check("reset out_bus", 256'(out_bus), 256'(0));
            tick();
        end
        rst = 1'b0;
        start = 1'b0;
        tick();
        @(negedge clk);
        check("stray valids ignored busy", 256'(busy), 256'(0));
        check("stray valids ignored w_ready", 256'(w_ready), 256'(0));
        tick();
        w_valid = 1'b0;
        a_valid = 1'b0;

        // Identity weights, table-driven vectors.
        for (int k = 0; k < R; k++) w_rows[k] = 64'(1) << ((R - 1 - k) * W);
        a_vecs.delete();
        for (int i = 0; i < 4; i++) a_vecs.push_back(tbl[i].a);
        obs.delete();
        do_start(4, t0);
        load_w(1'b0);
        stream(4, 0, 1'b0);
        wait_done(t0, 2 * R + C + 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            v = obs[i];
            check("identity result", 256'(v), 256'(tbl[i].y));
        end

        // Signed weights with bubbles.
        for (int k = 0; k < R; k++) w_rows[k] = '1;
        a_vecs.delete();
        for (int i = 0; i < 4; i++) a_vecs.push_back({R{8'h7f}});
        vpat = '{1, 0, 1, 1, 0, 1};
        obs.delete();
        do_start(4, t0);
        load_w(1'b0);
        stream(4, 1, 1'b0);
        wait_done(t0, 2 * R + C + 4 + 2, 1'b1);
        v = obs[0];
        lane = v[A-1:0];
        check("bubble lane -1016", 256'(lane), 256'(24'hfffc08));

        // Overflow on the 16-bit twin.
        for (int k = 0; k < R; k++) w_rows[k] = {C{8'h80}};
        a_vecs.delete();
        a_vecs.push_back({R{8'h80}});
        do_start(1, t0);
        load_w(1'b0);
        stream(1, 0, 1'b0);
        wait_done(t0, 2 * R + C + 1, 1'b1);
`ifdef WS_SYSTOLIC_SATURATE_EN
        sat_exp = 16'h7fff;
`else
        sat_exp = 16'h0000;
`endif
        for (int c = 0; c < C; c++) check("acc16 overflow lane", 256'(last16[c*16 +: 16]),
                                          256'(sat_exp));

        // start with num_vec = 0 stays idle.
        start = 1'b1;
        num_vec = 16'd0;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("zero-length start busy", 256'(busy), 256'(0));
        check("zero-length start w_ready", 256'(w_ready), 256'(0));
        tick();

        // start during COMPUTE is ignored.
        rand_weights();
        rand_acts(5);
        do_start(5, t0);
        load_w(1'b0);
        stream(5, 0, 1'b1);
        wait_done(t0, 2 * R + C + 5, 1'b1);

        // Reset mid-COMPUTE discards the job.
        rand_weights();
        rand_acts(10);
        do_start(10, t0);
        load_w(1'b0);
        stream(3, 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("reset mid-job busy", 256'(busy), 256'(0));
        check("reset mid-job a_ready", 256'(a_ready), 256'(0));
        n = done_cnt;
        repeat (30) tick();
        check("no done after reset", 256'(done_cnt - n), 256'(0));

        // Fresh jobs with random data and handshake stalls.
        for (int j = 0; j < 3; j++) begin
            n = $urandom_range(5, 20);
            rand_weights();
            rand_acts(n);
            do_start(n, t0);
            load_w(1'b1);
            stream(n, 2, 1'b0);
            wait_done(t0, 0, 1'b0);
        end

        check("no pending results", 256'(exp_q.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
